register_read_system: RTL

Upstream neighbour of the ALU stage in the 16-bit multicycle processor. Latches the fetched instruction into an instruction register and decodes its register fields. It reads the 16-entry register file through two ports and generates the immediate. The A, B and Imm values are registered so that they can drive the ALU stage's operand inputs directly. The block also owns the register-file write port used by writeback.

---
 rtl/register_read_system_pkg.sv | 39 +++
 rtl/register_read_system_regfile.sv | 32 +++
 rtl/register_read_system.sv | 68 ++++++
 3 files changed

// File: rtl/register_read_system_pkg.sv
// Shared processor-wide constants, field positions and immediate formats.
// Imported by the register-read stage and its register file.
package register_read_system_pkg;

  localparam int DATA_W     = 16;
  localparam int NREG       = 16;
  localparam int REG_ADDR_W = 4;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RA_HI  = 11;
  localparam int RA_LO  = 8;
  localparam int RB_HI  = 7;
  localparam int RB_LO  = 4;

  typedef enum logic [1:0] {
    IMM_SEXT8 = 2'd0,
    IMM_ZEXT8 = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_SEXT4 = 2'd3
  } imm_sel_e;

  function automatic logic [DATA_W-1:0] gen_imm(
    input logic [DATA_W-1:0] ir,
    input imm_sel_e          sel
  );
    logic [DATA_W-1:0] imm;
    imm = '0;
    unique case (1'b1)
      sel == IMM_SEXT8: imm = {{8{ir[7]}}, ir[7:0]};
      sel == IMM_ZEXT8: imm = {8'h00, ir[7:0]};
      sel == IMM_UPPER: imm = {ir[7:0], 8'h00};
      sel == IMM_SEXT4: imm = {{12{ir[3]}}, ir[3:0]};
      default:          imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_read_system_regfile.sv
// 16x16 register file: two async read ports, one sync write port.
// r0 is never written and always reads zero.
module register_file_16
  import register_read_system_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [REG_ADDR_W-1:0] addr_a,
  input  logic [REG_ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0]     data_a,
  output logic [DATA_W-1:0]     data_b
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign data_a = (addr_a == '0) ? '0 : regs[addr_a];
  assign data_b = (addr_b == '0) ? '0 : regs[addr_b];

endmodule

// File: rtl/register_read_system.sv
// Register-read stage: IR, field decode, regfile read with write bypass,
// and registered A/B/Imm operands for the ALU stage.
module register_read_system
  import register_read_system_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     instr,
  input  logic                  IRwrite,
  input  logic [1:0]            ImmSel,
  input  logic                  RegWrite,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [3:0]            opcode,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  output logic [DATA_W-1:0]     Imm
);

  logic [DATA_W-1:0]     ir;
  logic [REG_ADDR_W-1:0] ra;
  logic [REG_ADDR_W-1:0] rb;
  logic [DATA_W-1:0]     rf_a;
  logic [DATA_W-1:0]     rf_b;
  logic [DATA_W-1:0]     rd_a;
  logic [DATA_W-1:0]     rd_b;
  logic                  byp_a;
  logic                  byp_b;

  assign opcode = ir[OPC_HI:OPC_LO];
  assign ra     = ir[RA_HI:RA_LO];
  assign rb     = ir[RB_HI:RB_LO];

  register_file_16 u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (RegWrite),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .addr_a  (ra),
    .addr_b  (rb),
    .data_a  (rf_a),
    .data_b  (rf_b)
  );

  // Forward the committing write so A/B see it on the same edge.
  assign byp_a = RegWrite && wr_addr == ra && ra != '0;
  assign byp_b = RegWrite && wr_addr == rb && rb != '0;
  assign rd_a  = byp_a ? wr_data : rf_a;
  assign rd_b  = byp_b ? wr_data : rf_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      ir  <= '0;
      A   <= '0;
      B   <= '0;
      Imm <= '0;
    end else begin
      if (IRwrite) begin
        ir <= instr;
      end
      A   <= rd_a;
      B   <= rd_b;
      Imm <= gen_imm(ir, imm_sel_e'(ImmSel));
    end
  end

endmodule
